// File: rtl/fcmp_pkg.sv
// Shared types and FP32 field constants for the fcmp_sched comparator sequencer.
package fcmp_pkg;

  localparam int unsigned FP_W    = 32;
  localparam int unsigned EXP_MSB = 30;
  localparam int unsigned EXP_LSB = 23;
  localparam int unsigned MAN_MSB = 22;
  localparam logic [7:0]  EXP_ALL1 = 8'hFF;

  typedef enum logic [1:0] {
    FCMP_FLT = 2'b00,
    FCMP_FLE = 2'b01,
    FCMP_FEQ = 2'b10,
    FCMP_RSV = 2'b11
  } fcmp_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS1 = 2'b01,
    PASS2 = 2'b10,
    RESP  = 2'b11
  } fcmp_state_e;

  typedef struct packed {
    fcmp_op_e        op;
    logic [FP_W-1:0] x1;
    logic [FP_W-1:0] x2;
  } fcmp_req_t;

  function automatic logic is_nan(input logic [FP_W-1:0] x);
    return (x[EXP_MSB:EXP_LSB] == EXP_ALL1) && (x[MAN_MSB:0] != '0);
  endfunction

endpackage

// File: rtl/fcmp_rr_arb.sv
// Two-way round-robin grant; the pointer flips away from whichever side was granted.
module fcmp_rr_arb (
  input  logic clk,
  input  logic rstn,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic grant0,
  output logic grant1
);

  logic ptr_q;  // 0: req0 has priority, 1: req1 has priority

  assign grant0 = valid0 & (~valid1 | ~ptr_q);
  assign grant1 = valid1 & (~valid0 |  ptr_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= 1'b0;
    end else if (advance) begin
      ptr_q <= grant0;
    end
  end

endmodule

// File: rtl/flt.sv
// IEEE single less-than on sign/magnitude; +0 and -0 compare equal, no NaN handling.
module flt (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt
);

  logic [30:0] mag_a;
  logic [30:0] mag_b;

  assign mag_a = a[30:0];
  assign mag_b = b[30:0];

  always_comb begin
    lt = 1'b0;
    if ((mag_a == '0) && (mag_b == '0)) begin
      lt = 1'b0;
    end else if (a[31] != b[31]) begin
      lt = a[31];
    end else if (a[31]) begin
      lt = (mag_a > mag_b);
    end else begin
      lt = (mag_a < mag_b);
    end
  end

endmodule

// File: rtl/fcmp_sched.sv
// Shares one flt comparator between two requesters for FLT/FLE/FEQ.
// Define FCMP_NAN_EN to force NaN-operand results to 0 in a single pass.
module fcmp_sched
  import fcmp_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [31:0]      req0_x1,
  input  logic [31:0]      req0_x2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [31:0]      req1_x1,
  input  logic [31:0]      req1_x2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_y,
  output logic             resp_src,
  output logic [TAG_W-1:0] resp_tag
);

  fcmp_state_e      state_q, state_d;
  fcmp_req_t        cur_q, in_req;
  logic [TAG_W-1:0] tag_q;
  logic             src_q;
  logic             lt1_q;
  logic             grant0, grant1;
  logic             accept_ok, accept;
  logic             set_resp, resp_done, y_c;
  logic             swap, lt, flagged;
  logic [31:0]      cmp_a, cmp_b;

  fcmp_rr_arb u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .advance (accept),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  assign req0_ready = grant0 & accept_ok;
  assign req1_ready = grant1 & accept_ok;

  assign in_req = grant1 ? '{op: fcmp_op_e'(req1_op), x1: req1_x1, x2: req1_x2}
                         : '{op: fcmp_op_e'(req0_op), x1: req0_x1, x2: req0_x2};

  // Second FEQ pass and FLE both feed the operands reversed
  assign swap  = (state_q == PASS2) | (cur_q.op == FCMP_FLE);
  assign cmp_a = swap ? cur_q.x2 : cur_q.x1;
  assign cmp_b = swap ? cur_q.x1 : cur_q.x2;

  flt u_flt (
    .a  (cmp_a),
    .b  (cmp_b),
    .lt (lt)
  );

`ifdef FCMP_NAN_EN
  logic nan_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nan_q <= 1'b0;
    end else if (accept) begin
      nan_q <= is_nan(in_req.x1) | is_nan(in_req.x2);
    end
  end

  assign flagged = nan_q;
`else
  assign flagged = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, accept window and pass result
  always_comb begin
    state_d   = state_q;
    accept_ok = 1'b0;
    set_resp  = 1'b0;
    resp_done = 1'b0;
    y_c       = 1'b0;
    case (state_q)
      IDLE: accept_ok = rstn;
      PASS1: begin
        if ((cur_q.op == FCMP_FEQ) && !flagged) begin
          state_d = PASS2;
        end else begin
          state_d  = RESP;
          set_resp = 1'b1;
          if (!flagged) begin
            case (cur_q.op)
              FCMP_FLT: y_c = lt;
              FCMP_FLE: y_c = ~lt;
              default:  y_c = 1'b0;
            endcase
          end
        end
      end
      PASS2: begin
        state_d  = RESP;
        set_resp = 1'b1;
        y_c      = ~lt1_q & ~lt;
      end
      RESP: begin
        if (resp_ready) begin
          resp_done = 1'b1;
          accept_ok = rstn;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    accept = accept_ok & (grant0 | grant1);
    if (accept) begin
      state_d = PASS1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_q <= '0;
      tag_q <= '0;
      src_q <= 1'b0;
      lt1_q <= 1'b0;
    end else begin
      if (accept) begin
        cur_q <= in_req;
        tag_q <= grant1 ? req1_tag : req0_tag;
        src_q <= grant1;
      end
      if (state_q == PASS1) begin
        lt1_q <= lt;
      end
    end
  end

  // Response register holds until the consumer takes it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_valid <= 1'b0;
      resp_y     <= 1'b0;
      resp_src   <= 1'b0;
      resp_tag   <= '0;
    end else if (set_resp) begin
      resp_valid <= 1'b1;
      resp_y     <= y_c;
      resp_src   <= src_q;
      resp_tag   <= tag_q;
    end else if (resp_done) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fcmp_sched.sv
// Randomized and directed bench for fcmp_sched against a transaction-level model.
module tb_fcmp_sched;

  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req0_valid, req0_ready;
  logic [1:0]       req0_op;
  logic [31:0]      req0_x1, req0_x2;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [1:0]       req1_op;
  logic [31:0]      req1_x1, req1_x2;
  logic [TAG_W-1:0] req1_tag;
  logic             resp_valid, resp_ready, resp_y, resp_src;
  logic [TAG_W-1:0] resp_tag;

  always #5 clk = ~clk;

  fcmp_sched #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x1(req0_x1), .req0_x2(req0_x2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x1(req1_x1), .req1_x2(req1_x2), .req1_tag(req1_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
    .resp_src(resp_src), .resp_tag(resp_tag)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic longint fkey(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic bit ref_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic bit ref_flagged(input logic [31:0] a, input logic [31:0] b);
`ifdef FCMP_NAN_EN
    return ref_nan(a) || ref_nan(b);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit ref_y(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (ref_flagged(a, b)) return 1'b0;
    case (op)
      2'd0:    return fkey(a) < fkey(b);
      2'd1:    return fkey(a) <= fkey(b);
      2'd2:    return fkey(a) == fkey(b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op == 2'd2 && !ref_flagged(a, b)) ? 3 : 2;
  endfunction

  // ---------------- transaction model + per-cycle compare ----------------
  int         m_ptr, m_left, resp_cnt;
  bit         m_busy, m_have, m_y, m_src, p_y, p_src;
  logic [4:0] m_tag, p_tag;
  bit         acc_ok, v0, v1;
  int         win;

  always @(negedge clk) begin
    if (!rstn) begin
      m_ptr = 0; m_busy = 0; m_have = 0; m_left = 0;
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_ready0", 32'(req0_ready), 32'd0);
      check("rst_ready1", 32'(req1_ready), 32'd0);
    end else begin
      check("resp_valid", 32'(resp_valid), 32'(m_have));
      if (m_have) begin
        check("resp_y", 32'(resp_y), 32'(m_y));
        check("resp_src", 32'(resp_src), 32'(m_src));
        check("resp_tag", 32'(resp_tag), 32'(m_tag));
      end
      acc_ok = !m_busy && (!m_have || resp_ready);
      v0 = req0_valid;
      v1 = req1_valid;
      win = (v0 && v1) ? m_ptr : (v0 ? 0 : 1);
      check("ready0", 32'(req0_ready), 32'(acc_ok && v0 && win == 0));
      check("ready1", 32'(req1_ready), 32'(acc_ok && v1 && win == 1));
      if (m_have && resp_ready) begin
        m_have = 0;
        resp_cnt++;
      end
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_have = 1; m_y = p_y; m_src = p_src; m_tag = p_tag;
        end
      end
      if (acc_ok && (v0 || v1)) begin
        if (win == 0) begin
          p_y = ref_y(req0_op, req0_x1, req0_x2); p_tag = req0_tag;
          m_left = ref_lat(req0_op, req0_x1, req0_x2) - 1;
        end else begin
          p_y = ref_y(req1_op, req1_x1, req1_x2); p_tag = req1_tag;
          m_left = ref_lat(req1_op, req1_x1, req1_x2) - 1;
        end
        p_src = (win == 1);
        m_busy = 1;
        m_ptr = 1 - win;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int r, input bit v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    if (r == 0) begin
      req0_valid = v; req0_op = op; req0_x1 = a; req0_x2 = b; req0_tag = t;
    end else begin
      req1_valid = v; req1_op = op; req1_x1 = a; req1_x2 = b; req1_tag = t;
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] tbl [10];
    tbl = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000, 32'h40000000,
            32'h7F800000, 32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h80000001};
    if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 9)];
    return $urandom;
  endfunction

  task automatic rand_req(input int r, input bit v);
    logic [31:0] a, b;
    int sel;
    a = rand_fp();
    sel = $urandom_range(0, 9);
    b = (sel < 3) ? a : (sel == 3) ? {~a[31], a[30:0]} : rand_fp();
    set_req(r, v, 2'($urandom_range(0, 3)), a, b, 5'($urandom));
  endtask

  task automatic do_reset();
    @(posedge clk); #2; rstn = 1'b0;
    @(negedge clk);
    @(posedge clk); #2; rstn = 1'b1;
  endtask

  // Issue one op with resp_ready=1 and measure latency from the accepting cycle
  task automatic do_op(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input bit exp_y, input int exp_lat, input string nm);
    bit got;
    int k;
    @(posedge clk); #1;
    set_req(r, 1'b1, op, a, b, t);
    resp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (r == 0) ? req0_ready : req1_ready;
    end
    check({nm, "_accept"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    set_req(r, 1'b0, op, a, b, t);
    k = 1; got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1; else k++;
    end
    check({nm, "_lat"}, 32'(k), 32'(exp_lat));
    check({nm, "_y"}, 32'(resp_y), 32'(exp_y));
    check({nm, "_src"}, 32'(resp_src), 32'(r));
    check({nm, "_tag"}, 32'(resp_tag), 32'(t));
  endtask

  int         glog [$];
  int         n0, n1, k;
  bit         h0, h1, seen;
  logic       hy, hs;
  logic [4:0] ht;

  initial begin
    rstn = 1'b0; resp_ready = 1'b0;
    set_req(0, 1'b1, 2'd0, 32'h3F800000, 32'h40000000, 5'd1);
    set_req(1, 1'b1, 2'd0, 32'h3F800000, 32'h40000000, 5'd2);
    repeat (3) @(posedge clk);
    #2;
    check("reset_y", 32'(resp_y), 32'd0);
    check("reset_src", 32'(resp_src), 32'd0);
    check("reset_tag", 32'(resp_tag), 32'd0);
    check("reset_ready0", 32'(req0_ready), 32'd0);
    set_req(0, 1'b0, 2'd0, 0, 0, 0);
    set_req(1, 1'b0, 2'd0, 0, 0, 0);
    rstn = 1'b1;

    // model pins
    check("model_flt_1_2", 32'(ref_y(2'd0, 32'h3F800000, 32'h40000000)), 32'd1);
    check("model_feq_pz_nz", 32'(ref_y(2'd2, 32'h00000000, 32'h80000000)), 32'd1);
    check("model_fle_neg", 32'(ref_y(2'd1, 32'hC0000000, 32'hBF800000)), 32'd1);

    // directed vectors
    do_op(0, 2'd0, 32'h3F800000, 32'h40000000, 5'd3,  1'b1, 2, "flt_1_2");
    do_op(0, 2'd0, 32'h40000000, 32'h3F800000, 5'd4,  1'b0, 2, "flt_2_1");
    do_op(1, 2'd1, 32'h40400000, 32'h40400000, 5'd5,  1'b1, 2, "fle_3_3");
    do_op(1, 2'd2, 32'h40400000, 32'h40400000, 5'd6,  1'b1, 3, "feq_3_3");
    do_op(1, 2'd2, 32'h00000000, 32'h80000000, 5'd7,  1'b1, 3, "feq_pz_nz");
    do_op(0, 2'd2, 32'hBF800000, 32'h3F800000, 5'd8,  1'b0, 3, "feq_m1_p1");
    do_op(0, 2'd3, 32'h3F800000, 32'h40000000, 5'd9,  1'b0, 2, "rsv");
`ifdef FCMP_NAN_EN
    do_op(0, 2'd2, 32'h7FC00000, 32'h7FC00000, 5'd10, 1'b0, 2, "feq_nan");
    do_op(1, 2'd0, 32'h3F800000, 32'h7F800001, 5'd11, 1'b0, 2, "flt_nan");
`else
    do_op(0, 2'd2, 32'h7FC00000, 32'h7FC00000, 5'd10, 1'b1, 3, "feq_nan");
    do_op(1, 2'd0, 32'h3F800000, 32'h7F800001, 5'd11, 1'b1, 2, "flt_nan");
`endif

    // fairness: both requesters always valid
    do_reset();
    @(posedge clk); #1;
    resp_ready = 1'b1;
    n0 = 0; n1 = 0;
    rand_req(0, 1'b1); req0_tag = 5'd0;
    rand_req(1, 1'b1); req1_tag = 5'd16;
    for (int c = 0; c < 200 && (n0 < 8 || n1 < 8); c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (h0) begin glog.push_back(0); n0++; end
      if (h1) begin glog.push_back(1); n1++; end
      @(posedge clk); #1;
      if (h0) begin rand_req(0, n0 < 8); req0_tag = 5'(n0); end
      if (h1) begin rand_req(1, n1 < 8); req1_tag = 5'(16 + n1); end
    end
    check("fair_count", 32'(glog.size()), 32'd16);
    for (int i = 0; i < glog.size(); i++) check("fair_order", 32'(glog[i]), 32'(i % 2));
    set_req(0, 1'b0, 2'd0, 0, 0, 0);
    set_req(1, 1'b0, 2'd0, 0, 0, 0);
    repeat (4) @(posedge clk);

    // backpressure with a waiting request
    #1;
    resp_ready = 1'b0;
    set_req(0, 1'b1, 2'd1, 32'hC0000000, 32'hBF800000, 5'd21);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = req0_ready; end
    check("bp_accept", 32'(seen), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    set_req(1, 1'b1, 2'd0, 32'h3F800000, 32'h40000000, 5'd22);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = resp_valid; end
    check("bp_resp", 32'(seen), 32'd1);
    hy = resp_y; hs = resp_src; ht = resp_tag;
    check("bp_y", 32'(hy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_y", 32'(resp_y), 32'(hy));
      check("bp_hold_src", 32'(resp_src), 32'(hs));
      check("bp_hold_tag", 32'(resp_tag), 32'(ht));
      check("bp_ready1", 32'(req1_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_same_cycle_accept", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (4) @(posedge clk);

    // reset during the second FEQ pass
    #1;
    set_req(0, 1'b1, 2'd2, 32'h40400000, 32'h40400000, 5'd25);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = req0_ready; end
    check("rst_feq_accept", 32'(seen), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    set_req(1, 1'b1, 2'd0, 32'h3F800000, 32'h40000000, 5'd26);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("rst_async_valid", 32'(resp_valid), 32'd0);
    check("rst_async_ready1", 32'(req1_ready), 32'd0);
    check("rst_async_tag", 32'(resp_tag), 32'd0);
    @(negedge clk);
    @(posedge clk); #2;
    rstn = 1'b1;
    req1_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); seen |= resp_valid; end
    check("rst_no_resp", 32'(seen), 32'd0);
    do_op(1, 2'd2, 32'h40400000, 32'h40400000, 5'd27, 1'b1, 3, "post_rst_feq");

    // randomized traffic with random backpressure
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (!req0_valid || h0) rand_req(0, $urandom_range(0, 2) != 0);
      if (!req1_valid || h1) rand_req(1, $urandom_range(0, 2) != 0);
      resp_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("drain_idle", 32'(resp_valid), 32'd0);
    check("resp_seen", 32'(resp_cnt > 100), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
